// File: rtl/pampy_ula_pkg.sv
// rtl/pampy_ula_pkg.sv - opcodes and FSM states shared by the pamPy ALU and the control unit
package pampy_ula_pkg;

    localparam logic [3:0] ULA_ADD = 4'd0;
    localparam logic [3:0] ULA_SUB = 4'd1;
    localparam logic [3:0] ULA_MUL = 4'd2;
    localparam logic [3:0] ULA_DIV = 4'd3;
    localparam logic [3:0] ULA_MOD = 4'd4;
    localparam logic [3:0] ULA_AND = 4'd5;
    localparam logic [3:0] ULA_OR  = 4'd6;
    localparam logic [3:0] ULA_XOR = 4'd7;
    localparam logic [3:0] ULA_NOT = 4'd8;
    localparam logic [3:0] ULA_SHL = 4'd9;
    localparam logic [3:0] ULA_SHR = 4'd10;
    localparam logic [3:0] ULA_EQ  = 4'd11;
    localparam logic [3:0] ULA_LT  = 4'd12;
    localparam logic [3:0] ULA_GT  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_FINISH  = 2'd2
    } ula_state_t;

endpackage

// File: rtl/ula_div_seq.sv
// rtl/ula_div_seq.sv - iterative unsigned restoring divider, one quotient bit per clock
module ula_div_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  done
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] dvsr;
    logic [DW-1:0] src_q, src_r, src_d;
    logic [DW-1:0] step_q, step_r;
    logic [DW:0]   trial;
    logic          running;
    logic [CW-1:0] cnt;

    // The first bit is resolved on the start edge straight from the inputs.
    always_comb begin
        src_q = start ? dividend : quotient;
        src_r = start ? '0 : remainder;
        src_d = start ? divisor : dvsr;
        trial = {src_r, src_q[DW-1]};
        if (trial >= {1'b0, src_d}) begin
            step_r = DW'(trial - {1'b0, src_d});
            step_q = {src_q[DW-2:0], 1'b1};
        end else begin
            step_r = trial[DW-1:0];
            step_q = {src_q[DW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quotient  <= '0;
            remainder <= '0;
            dvsr      <= '0;
            running   <= 1'b0;
            cnt       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= step_q;
                remainder <= step_r;
                dvsr      <= divisor;
                running   <= 1'b1;
                cnt       <= CW'(DW - 1);
            end else if (running) begin
                quotient  <= step_q;
                remainder <= step_r;
                cnt       <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ula_ops_seq.sv
// rtl/ula_ops_seq.sv - pamPy ALU with operand registers and start/busy/done handshake; PAMPY_ULA_DIV_EN adds DIV/MOD
module ula_ops_seq
    import pampy_ula_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ULA_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] op_in,
    input  logic                  ld_op1,
    input  logic                  ld_op2,
    input  logic [ADDR_WIDTH-1:0] tos_in,
    input  logic                  ctrl_stack_comp,
    input  logic [3:0]            sel_ula,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ULA_WIDTH-1:0]  ula_out,
    output logic                  overflow_out,
    output logic                  div0_out,
    output logic                  err_out,
    output logic                  stack_comp_out
);
    localparam int DW = DATA_WIDTH;

    logic [DW-1:0]        op1, op2;
    logic [DW:0]          sum, diff;
    logic [2*DW-1:0]      prod;
    logic [DW-1:0]        not_res, shl_res, shr_res;
    logic [ULA_WIDTH-1:0] alu_res, div_res;
    logic                 alu_ovf, alu_div0, alu_err;
    logic                 accept, wr_alu, wr_div;

    assign accept  = start && !busy;
    assign sum     = {1'b0, op1} + {1'b0, op2};
    assign diff    = {1'b0, op1} - {1'b0, op2};
    assign prod    = {{DW{1'b0}}, op1} * {{DW{1'b0}}, op2};
    assign not_res = ~op1;
    assign shl_res = op1 << op2[2:0];
    assign shr_res = op1 >> op2[2:0];

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_div0 = 1'b0;
        alu_err  = 1'b0;
        case (sel_ula)
            ULA_ADD: begin
                alu_res = ULA_WIDTH'(sum);
                alu_ovf = sum[DW];
            end
            ULA_SUB: begin
                alu_res = ULA_WIDTH'(diff[DW-1:0]);
                alu_ovf = diff[DW];
            end
            ULA_MUL: begin
                alu_res = ULA_WIDTH'(prod);
                alu_ovf = |prod[2*DW-1:DW];
            end
            ULA_DIV, ULA_MOD: begin
`ifdef PAMPY_ULA_DIV_EN
                // Non-zero divisors go to the divider; only divide-by-zero completes here.
                alu_res  = '1;
                alu_div0 = 1'b1;
`else
                alu_err  = 1'b1;
`endif
            end
            ULA_AND: alu_res = ULA_WIDTH'(op1 & op2);
            ULA_OR:  alu_res = ULA_WIDTH'(op1 | op2);
            ULA_XOR: alu_res = ULA_WIDTH'(op1 ^ op2);
            ULA_NOT: alu_res = ULA_WIDTH'(not_res);
            ULA_SHL: alu_res = ULA_WIDTH'(shl_res);
            ULA_SHR: alu_res = ULA_WIDTH'(shr_res);
            ULA_EQ:  alu_res = ULA_WIDTH'(op1 == op2);
            ULA_LT:  alu_res = ULA_WIDTH'(op1 < op2);
            ULA_GT:  alu_res = ULA_WIDTH'(op1 > op2);
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op1 <= '0;
            op2 <= '0;
        end else if (!busy) begin
            if (ld_op1) op1 <= op_in;
            if (ld_op2) op2 <= op_in;
        end
    end

`ifdef PAMPY_ULA_DIV_EN
    ula_state_t    state, state_nxt;
    logic          div_start, div_done, div_is_mod;
    logic [DW-1:0] div_q, div_r;

    assign div_start = accept && (sel_ula == ULA_DIV || sel_ula == ULA_MOD) && (op2 != '0);
    assign busy      = (state != ST_IDLE);
    assign wr_alu    = accept && !div_start;
    assign wr_div    = (state == ST_FINISH);
    assign div_res   = ULA_WIDTH'(div_is_mod ? div_r : div_q);

    ula_div_seq #(
        .DATA_WIDTH(DW)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (op1),
        .divisor   (op2),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            div_is_mod <= 1'b0;
        end else begin
            state <= state_nxt;
            if (div_start) div_is_mod <= (sel_ula == ULA_MOD);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (div_start) state_nxt = ST_DIV_RUN;
            ST_DIV_RUN: if (div_done)  state_nxt = ST_FINISH;
            ST_FINISH:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end
`else
    assign busy    = 1'b0;
    assign wr_alu  = accept;
    assign wr_div  = 1'b0;
    assign div_res = '0;
`endif

    // Every completion rewrites all three flags so stale ones never linger.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ula_out        <= '0;
            overflow_out   <= 1'b0;
            div0_out       <= 1'b0;
            err_out        <= 1'b0;
            stack_comp_out <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= wr_alu || wr_div;
            if (ctrl_stack_comp) stack_comp_out <= (tos_in == '0);
            if (wr_alu) begin
                ula_out      <= alu_res;
                overflow_out <= alu_ovf;
                div0_out     <= alu_div0;
                err_out      <= alu_err;
            end else if (wr_div) begin
                ula_out      <= div_res;
                overflow_out <= 1'b0;
                div0_out     <= 1'b0;
                err_out      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_ops_seq.sv
// tb/tb_ula_ops_seq.sv - scoreboard bench for ula_ops_seq against an arithmetic reference model
`timescale 1ns/1ps
module tb_ula_ops_seq;
    import pampy_ula_pkg::*;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int UW = 24;
    localparam int unsigned MASK = (1 << DW) - 1;
`ifdef PAMPY_ULA_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] op_in = '0;
    logic          ld_op1 = 1'b0;
    logic          ld_op2 = 1'b0;
    logic [AW-1:0] tos_in = '0;
    logic          ctrl_stack_comp = 1'b0;
    logic [3:0]    sel_ula = '0;
    logic          start = 1'b0;
    logic          busy, done, overflow_out, div0_out, err_out, stack_comp_out;
    logic [UW-1:0] ula_out;

    ula_ops_seq #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ULA_WIDTH (UW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .op_in          (op_in),
        .ld_op1         (ld_op1),
        .ld_op2         (ld_op2),
        .tos_in         (tos_in),
        .ctrl_stack_comp(ctrl_stack_comp),
        .sel_ula        (sel_ula),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .ula_out        (ula_out),
        .overflow_out   (overflow_out),
        .div0_out       (div0_out),
        .err_out        (err_out),
        .stack_comp_out (stack_comp_out)
    );

    typedef struct {
        int unsigned res;
        bit          ovf;
        bit          div0;
        bit          err;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int op, input int unsigned a, input int unsigned b);
        exp_t e;
        int unsigned r;
        r = 0;
        e.ovf = 0; e.div0 = 0; e.err = 0; e.cyc = 0;
        case (op)
            0:  begin r = a + b; e.ovf = (r > MASK); end
            1:  begin r = (a - b) & MASK; e.ovf = (a < b); end
            2:  begin r = a * b; e.ovf = (r > MASK); end
            3, 4: begin
                if (!DIV_EN) e.err = 1;
                else if (b == 0) begin r = (1 << UW) - 1; e.div0 = 1; end
                else r = (op == 3) ? a / b : a % b;
            end
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = ~a & MASK;
            9:  r = (a << (b % 8)) & MASK;
            10: r = a >> (b % 8);
            11: r = (a == b) ? 1 : 0;
            12: r = (a < b) ? 1 : 0;
            13: r = (a > b) ? 1 : 0;
            default: e.err = 1;
        endcase
        e.res = r;
        return e;
    endfunction

    function automatic int latency(input int op, input int unsigned b);
        return (DIV_EN && (op == 3 || op == 4) && b != 0) ? DW + 1 : 0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("ula_out", ula_out, e.res);
                check("overflow_out", overflow_out, e.ovf);
                check("div0_out", div0_out, e.div0);
                check("err_out", err_out, e.err);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input int op, input int unsigned a, input int unsigned b,
                          input bit mid_start, input bit ld_with_start);
        exp_t e;
        int   busy_cnt;
        int   lat;
        bit   finished;
        @(negedge clk);
        op_in = DW'(a); ld_op1 = 1'b1;
        @(negedge clk);
        op_in = DW'(b); ld_op1 = 1'b0; ld_op2 = 1'b1;
        @(negedge clk);
        ld_op2 = 1'b0; sel_ula = 4'(op); start = 1'b1;
        if (ld_with_start) begin
            ld_op1 = 1'b1;
            op_in  = DW'(~a);
        end
        lat   = latency(op, b);
        e     = model(op, a, b);
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        busy_cnt = 0;
        finished = 0;
        for (int i = 0; i < 40 && !finished; i++) begin
            @(negedge clk);
            ld_op1  = 1'b0;
            start   = mid_start && (i == 3);
            sel_ula = start ? ULA_ADD : 4'(op);
            if (busy) busy_cnt++;
            finished = (sb.size() == 0);
        end
        start = 1'b0;
        if (!finished) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: got no done for op %0d, expected done within 40 cycles", op);
            sb.delete();
        end
        check("busy_cycles", busy_cnt, lat);
    endtask

    task automatic stack_chk(input int tos, input bit strobe, input bit exp);
        @(negedge clk);
        tos_in = AW'(tos); ctrl_stack_comp = strobe;
        @(negedge clk);
        ctrl_stack_comp = 1'b0;
        check("stack_comp_out", stack_comp_out, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ula_out", ula_out, 0);
        check("reset_flags", {overflow_out, div0_out, err_out, stack_comp_out}, 0);
        check("reset_busy_done", {busy, done}, 0);
        reset = 1'b1;

        run_op(0, 200, 100, 0, 0);
        run_op(2, 16, 16, 0, 0);
        run_op(2, 15, 17, 0, 0);
        run_op(3, 200, 7, 1, 0);
        run_op(4, 200, 7, 0, 0);
        run_op(3, 200, 0, 0, 0);
        run_op(0, 1, 1, 0, 0);
        run_op(4, 9, 0, 0, 0);
        run_op(15, 3, 3, 0, 0);
        run_op(14, 3, 3, 0, 0);
        run_op(1, 5, 9, 0, 0);
        run_op(9, 8'h81, 9, 0, 0);
        run_op(10, 8'h81, 15, 0, 0);
        run_op(3, 255, 1, 0, 1);
        run_op(4, 7, 200, 0, 0);
        run_op(0, 255, 255, 0, 1);

        stack_chk(0, 1, 1);
        stack_chk(5, 0, 1);
        stack_chk(5, 1, 0);
        stack_chk(0, 1, 1);

        // Reset in the middle of a divide aborts it without a done pulse.
        @(negedge clk);
        op_in = 8'd200; ld_op1 = 1'b1;
        @(negedge clk);
        op_in = 8'd7; ld_op1 = 1'b0; ld_op2 = 1'b1;
        @(negedge clk);
        ld_op2 = 1'b0; sel_ula = ULA_DIV; start = 1'b1;
        if (!DIV_EN) begin
            sb.push_back(model(3, 200, 7));
            sb[$].cyc = cyc + 1;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ula_out", ula_out, 0);
        check("abort_flags", {overflow_out, div0_out, err_out, stack_comp_out}, 0);
        check("abort_busy_done", {busy, done}, 0);
        sb.delete();
        repeat (DW + 2) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        reset = 1'b1;
        run_op(0, 1, 1, 0, 0);

        for (int k = 0; k < 120; k++) begin
            int unsigned a, b;
            a = $urandom_range(0, MASK);
            b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, MASK);
            run_op(int'($urandom_range(0, 15)), a, b,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ula_ops_seq.md
# ula_ops_seq

Parametrised successor to the single-cycle ALU operations block in the pamPy stack datapath. It holds two operand registers loaded from the stack output and executes a 4-bit-coded operation on a start/busy/done handshake. Single-cycle operations finish in one cycle. DIV/MOD run on an iterative restoring divider. It registers the result, the overflow/divide-by-zero/illegal-op flags and the stack-empty compare flag for the control unit.

## Interface
- DATA_WIDTH, 8: stack word width; operands are unsigned.
- ADDR_WIDTH, 12: width of the TOS pointer.
- ULA_WIDTH, 24: result width; must be ≥ 2·DATA_WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_in  in  DATA_WIDTH  stack output word, loaded into either operand register.
- ld_op1 / ld_op2  in  1  load op_in into OP1 / OP2; ignored while busy.
- tos_in  in  ADDR_WIDTH  current TOS pointer.
- ctrl_stack_comp  in  1  sample (tos_in == 0) into stack_comp_out.
- sel_ula  in  4  operation code, sampled with start.
- start  in  1  request an operation; accepted only when busy is low.
- busy  out  1  divider running.
- done  out  1  one-cycle pulse; results are valid.
- ula_out  out  ULA_WIDTH  registered result.
- overflow_out, div0_out, err_out  out  1  registered flags.
- stack_comp_out  out  1  registered stack-empty flag.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD
  - 5 AND, 6 OR, 7 XOR, 8 NOT(OP1)
  - 9 SHL(OP1 by OP2[2:0]), 10 SHR(OP1 by OP2[2:0])
  - 11 EQ, 12 LT, 13 GT; compare results are 1/0.
  - 14–15 illegal.
- ADD: exact (DATA_WIDTH+1)-bit sum, zero-extended. MUL: exact 2·DATA_WIDTH product, zero-extended. overflow_out = result > 2^DATA_WIDTH−1.
- SUB: OP1−OP2 wrapped to DATA_WIDTH bits. overflow_out = borrow (OP1 < OP2).
- Logic, shift and compare results: DATA_WIDTH bits, zero-extended. overflow_out=0; SHL-out bits are discarded.
- DIV/MOD: unsigned quotient/remainder, zero-extended.
- Divide by zero: ula_out = all ones, div0_out=1, single-cycle completion for both DIV and MOD.
- Illegal opcode: ula_out=0, err_out=1.
- Every completed operation rewrites all three flags; any flag not set by that operation is cleared.
- Operands captured at the start edge are used for the whole operation. ld_opX in the same cycle as start affects only the next operation.
- FSM:
  - IDLE: on start with DIV/MOD and divisor ≠ 0 → DIV_RUN; any other start completes in IDLE.
  - DIV_RUN: one quotient bit per cycle for DATA_WIDTH cycles → FINISH.
  - FINISH: write results, pulse done → IDLE.
- start while busy is ignored; no queueing.
- ctrl_stack_comp is independent of the FSM and is honoured in any state.

## Timing
- Reset values: ula_out=0; overflow_out, div0_out, err_out, stack_comp_out, busy, done = 0; OP1=OP2=0; state IDLE.
- Single-cycle op: start sampled at edge N → ula_out and flags updated at edge N; done high for the cycle after N.
- DIV/MOD: start at edge N → busy high from N to N+DATA_WIDTH+1; results and done at edge N+DATA_WIDTH+1. Total latency is DATA_WIDTH+1 cycles.
- A new start is accepted in the cycle done is high.
- stack_comp_out updates at the edge sampling ctrl_stack_comp.
- Reset asserted mid-divide: operation aborted, no done pulse, all outputs return to reset values immediately.

## Configuration
- PAMPY_ULA_DIV_EN defined: divider instantiated; DIV/MOD behave as above.
- Not defined: no divider and no DIV_RUN/FINISH states. Opcodes 3/4 complete single-cycle as illegal (ula_out=0, err_out=1), and busy is tied 0.

## Structure
- Package pampy_ula_pkg holds the opcode localparams (ULA_ADD…ULA_GT) and the FSM state enum. The control unit imports the same package.
- One sub-module, ula_div_seq: restoring divider with start/done and DATA_WIDTH parameter, returning quotient and remainder.

## Test plan
- DATA_WIDTH=8: OP1=200, OP2=100, ADD → ula_out=300 (0x12C), overflow_out=1, done one cycle after start.
- OP1=16, OP2=16, MUL → ula_out=256, overflow_out=1. Then 15×17 → 255, overflow_out=0.
- OP1=200, OP2=7: DIV → 28; MOD → 4. Each has busy high for 9 cycles and done at edge +9. A start pulsed mid-run is ignored.
- OP2=0, DIV → ula_out=0xFFFFFF, div0_out=1 after one cycle. Next ADD 1+1 → 2 with div0_out cleared.
- reset low at cycle 4 of a DIV → all outputs 0, no done pulse. After reset release, a new ADD completes normally.
- sel_ula=15 → ula_out=0, err_out=1. ctrl_stack_comp with tos_in=0 → stack_comp_out=1; with tos_in=5 → 0. Without PAMPY_ULA_DIV_EN, DIV → err_out=1 in one cycle.
